// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file's single write port: ALU vs. buffered loads,
// plus a pending-load scoreboard for decode hazards. Optional macro WB_BYPASS_EN adds bypass outputs.
module regfile_wb_sched #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  input  logic [AW-1:0]   chk_rd,
  output logic            hazard,
`ifdef WB_BYPASS_EN
  output logic            byp1_hit,
  output logic            byp2_hit,
  output logic [XLEN-1:0] byp_data,
`endif
  output logic            rf_wrt_en,
  output logic [AW-1:0]   rf_oprd,
  output logic [XLEN-1:0] rf_wrt_data
);

  localparam int unsigned PW   = $clog2(LQ_DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned NREG = 1 << AW;

  logic [AW-1:0]   rd_mem_q   [LQ_DEPTH];
  logic [AW-1:0]   rd_mem_d   [LQ_DEPTH];
  logic [XLEN-1:0] data_mem_q [LQ_DEPTH];
  logic [XLEN-1:0] data_mem_d [LQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREG-1:0] pend_q, pend_d, hz_vec;
  logic            rf_wrt_en_q, rf_wrt_en_d;
  logic [AW-1:0]   rf_oprd_q, rf_oprd_d;
  logic [XLEN-1:0] rf_wrt_data_q, rf_wrt_data_d;
  logic            full, empty, push, pop, alu_grant;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;
`ifdef WB_BYPASS_EN
  logic            rf_lsu_q, rf_lsu_d;
`endif

  // Arbitration: a full FIFO beats the ALU, the ALU beats a partially filled FIFO.
  always_comb begin
    full      = (cnt_q == CW'(LQ_DEPTH));
    empty     = (cnt_q == '0);
    head_rd   = rd_mem_q[rd_ptr_q];
    head_data = data_mem_q[rd_ptr_q];
    lsu_ready = rst & ~full;
    push      = lsu_valid & lsu_ready;
    pop       = 1'b0;
    alu_grant = 1'b0;
    alu_stall = 1'b0;
    if (full) begin
      pop       = 1'b1;
      alu_stall = alu_valid & rst;
    end else if (alu_valid && alu_rd != '0) begin
      alu_grant = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;
    end
  end

  always_comb begin
    rd_mem_d      = rd_mem_q;
    data_mem_d    = data_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    rf_wrt_en_d   = 1'b0;
    rf_oprd_d     = rf_oprd_q;
    rf_wrt_data_d = rf_wrt_data_q;
`ifdef WB_BYPASS_EN
    rf_lsu_d      = 1'b0;
`endif
    if (push) begin
      rd_mem_d[wr_ptr_q]   = lsu_rd;
      data_mem_d[wr_ptr_q] = lsu_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    // x0 loads still pop so that pending clears stay in issue order.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head_rd != '0) begin
        rf_wrt_en_d    = 1'b1;
        rf_oprd_d      = head_rd;
        rf_wrt_data_d  = head_data;
        pend_d[head_rd] = 1'b0;
`ifdef WB_BYPASS_EN
        rf_lsu_d       = 1'b1;
`endif
      end
    end else if (alu_grant) begin
      rf_wrt_en_d   = 1'b1;
      rf_oprd_d     = alu_rd;
      rf_wrt_data_d = alu_data;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (iss_valid && iss_rd != '0) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      pend_q        <= '0;
      rf_wrt_en_q   <= 1'b0;
      rf_oprd_q     <= '0;
      rf_wrt_data_q <= '0;
`ifdef WB_BYPASS_EN
      rf_lsu_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      rf_wrt_en_q   <= rf_wrt_en_d;
      rf_oprd_q     <= rf_oprd_d;
      rf_wrt_data_q <= rf_wrt_data_d;
`ifdef WB_BYPASS_EN
      rf_lsu_q      <= rf_lsu_d;
`endif
    end
  end

  // FIFO storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  always_comb begin
    hz_vec = pend_q;
`ifdef WB_BYPASS_EN
    if (rf_wrt_en_q && rf_lsu_q) hz_vec[rf_oprd_q] = 1'b0;
`endif
    hz_vec[0] = 1'b0;
    hazard = hz_vec[chk_rs1] | hz_vec[chk_rs2] | hz_vec[chk_rd];
  end

`ifdef WB_BYPASS_EN
  assign byp1_hit = rf_wrt_en_q & (rf_oprd_q == chk_rs1) & (rf_oprd_q != '0);
  assign byp2_hit = rf_wrt_en_q & (rf_oprd_q == chk_rs2) & (rf_oprd_q != '0);
  assign byp_data = rf_wrt_data_q;
`endif

  assign rf_wrt_en   = rf_wrt_en_q;
  assign rf_oprd     = rf_oprd_q;
  assign rf_wrt_data = rf_wrt_data_q;

endmodule
